// File: rtl/csr_file_v2.sv
// Machine-mode CSR file with interrupt trap/MRET redirect generation.
// Define CSR_COUNTERS_EN to add the 64-bit mcycle/minstret counters.
module csr_file_v2 #(
    parameter int          NUM_IRQ     = 4,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [11:0]        csr_addr,
    input  logic [1:0]         csr_op,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    output logic               csr_illegal,
    input  logic               instr_retire,
    input  logic               irq_accept,
    input  logic [31:0]        pc_in,
    input  logic               is_mret,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               timer_irq,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
`ifdef CSR_COUNTERS_EN
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;
`endif

    logic               r_mie_bit;
    logic               r_mpie_bit;
    logic [31:0]        r_mie;
    logic [31:0]        r_mtvec;
    logic [31:0]        r_mepc;
    logic [31:0]        r_mcause;
    logic [NUM_IRQ-1:0] r_sync [SYNC_STAGES];

    logic [31:0] w_mstatus;
    logic [31:0] w_mip;
    logic [31:0] w_pend;
    logic [31:0] w_old;
    logic [31:0] w_new;
    logic        w_hit;
    logic        w_we;
    logic        w_trap;
    logic [4:0]  w_code;
    logic [31:0] w_base;
    logic [31:0] w_tvec_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_sync[0] <= irq_i;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    always_comb begin
        w_mstatus    = '0;
        w_mstatus[3] = r_mie_bit;
        w_mstatus[7] = r_mpie_bit;
        w_mip        = '0;
        w_mip[7]     = timer_irq;
        w_mip[16 +: NUM_IRQ] = r_sync[SYNC_STAGES-1];
    end

    always_comb begin
        w_old = '0;
        w_hit = 1'b1;
        case (csr_addr)
            A_MSTATUS:   w_old = w_mstatus;
            A_MIE:       w_old = r_mie;
            A_MTVEC:     w_old = r_mtvec;
            A_MEPC:      w_old = r_mepc;
            A_MCAUSE:    w_old = r_mcause;
            A_MIP:       w_old = w_mip;
`ifdef CSR_COUNTERS_EN
            A_MCYCLE:    w_old = r_mcycle[31:0];
            A_MCYCLEH:   w_old = r_mcycle[63:32];
            A_MINSTRET:  w_old = r_minstret[31:0];
            A_MINSTRETH: w_old = r_minstret[63:32];
`endif
            default:     w_hit = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_op)
            2'b01:   w_new = csr_wdata;
            2'b10:   w_new = w_old | csr_wdata;
            2'b11:   w_new = w_old & ~csr_wdata;
            default: w_new = w_old;
        endcase
    end

    assign csr_rdata   = (csr_op != 2'b00) ? w_old : '0;
    assign csr_illegal = (csr_op != 2'b00) && (!w_hit || csr_addr == A_MIP);

    assign w_pend = w_mip & r_mie;
    assign w_trap = r_mie_bit && irq_accept && !is_mret && (w_pend != '0);
    assign w_we   = (csr_op != 2'b00) && w_hit && (csr_addr != A_MIP) && !w_trap;

    // Scan high to low so the lowest-numbered pending line wins; timer is the fallback.
    always_comb begin
        w_code = 5'd7;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_pend[16 + i]) w_code = 5'(16 + i);
        end
    end

    assign w_base    = {r_mtvec[31:2], 2'b00};
    assign w_tvec_pc = (r_mtvec[1:0] == 2'b01) ? w_base + {25'd0, w_code, 2'b00} : w_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mie_bit      <= 1'b0;
            r_mpie_bit     <= 1'b0;
            r_mie          <= '0;
            r_mtvec        <= RESET_MTVEC;
            r_mepc         <= '0;
            r_mcause       <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= 1'b0;
            if (w_we) begin
                case (csr_addr)
                    A_MSTATUS: begin
                        r_mie_bit  <= w_new[3];
                        r_mpie_bit <= w_new[7];
                    end
                    A_MIE:    r_mie    <= w_new;
                    A_MTVEC:  r_mtvec  <= w_new;
                    A_MEPC:   r_mepc   <= {w_new[31:2], 2'b00};
                    A_MCAUSE: r_mcause <= w_new;
                    default:  ;
                endcase
            end
            // Event updates come last so MRET overrides a same-cycle mstatus write.
            if (is_mret) begin
                r_mie_bit      <= r_mpie_bit;
                r_mpie_bit     <= 1'b1;
                redirect_valid <= 1'b1;
                redirect_pc    <= r_mepc;
            end else if (w_trap) begin
                r_mepc         <= {pc_in[31:2], 2'b00};
                r_mcause       <= {1'b1, 26'd0, w_code};
                r_mpie_bit     <= r_mie_bit;
                r_mie_bit      <= 1'b0;
                redirect_valid <= 1'b1;
                redirect_pc    <= w_tvec_pc;
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            if (w_we && csr_addr == A_MCYCLE)        r_mcycle[31:0]    <= w_new;
            else if (w_we && csr_addr == A_MCYCLEH)  r_mcycle[63:32]   <= w_new;
            else                                     r_mcycle          <= r_mcycle + 64'd1;
            if (w_we && csr_addr == A_MINSTRET)      r_minstret[31:0]  <= w_new;
            else if (w_we && csr_addr == A_MINSTRETH) r_minstret[63:32] <= w_new;
            else if (instr_retire)                   r_minstret        <= r_minstret + 64'd1;
        end
    end
`else
    logic w_unused;
    assign w_unused = instr_retire;
`endif
endmodule

// File: tb/tb_csr_file_v2.sv
// Directed self-checking bench for csr_file_v2: CSR ops, traps, MRET, reset.
module tb_csr_file_v2;
    localparam logic [31:0] RST_TVEC = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [1:0]  csr_op = '0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        instr_retire = 1'b0;
    logic        irq_accept = 1'b0;
    logic [31:0] pc_in = '0;
    logic        is_mret = 1'b0;
    logic [3:0]  irq_i = '0;
    logic        timer_irq = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    csr_file_v2 #(.NUM_IRQ(4), .RESET_MTVEC(RST_TVEC), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .csr_addr(csr_addr), .csr_op(csr_op),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .instr_retire(instr_retire), .irq_accept(irq_accept), .pc_in(pc_in),
        .is_mret(is_mret), .irq_i(irq_i), .timer_irq(timer_irq),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #10 clk = ~clk;

    task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        csr_addr = a; csr_op = op; csr_wdata = d;
        @(negedge clk);
        csr_op = 2'b00; csr_wdata = '0;
        $display("write addr=%h op=%0d data=%h", a, op, d);
    endtask

    // A set-bits op with a zero mask reads without modifying.
    task automatic rd(input logic [11:0] a, output logic [31:0] d);
        csr_addr = a; csr_op = 2'b10; csr_wdata = '0;
        #1 d = csr_rdata;
        csr_op = 2'b00;
        $display("read  addr=%h data=%h", a, d);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin errors++;
            $display("FAIL reset_redirect got v=%b pc=%h exp v=0 pc=0", redirect_valid, redirect_pc); end
        rd(12'h300, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mstatus got %h exp 0", d); end
        rd(12'h305, d);
        checks++; if (d !== RST_TVEC) begin errors++; $display("FAIL reset_mtvec got %h exp %h", d, RST_TVEC); end
        rd(12'h304, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mie got %h exp 0", d); end
        rd(12'h342, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mcause got %h exp 0", d); end
    endtask

    task automatic test_csr_ops();
        logic [31:0] d;
        wr(12'h300, 2'b01, 32'h8);
        rd(12'h300, d);
        checks++; if (d !== 32'h8) begin errors++; $display("FAIL mstatus_write got %h exp 8", d); end
        wr(12'h300, 2'b10, 32'h80);
        rd(12'h300, d);
        checks++; if (d !== 32'h88) begin errors++; $display("FAIL mstatus_set got %h exp 88", d); end
        wr(12'h300, 2'b11, 32'h8);
        rd(12'h300, d);
        checks++; if (d !== 32'h80) begin errors++; $display("FAIL mstatus_clear got %h exp 80", d); end
        wr(12'h341, 2'b01, 32'h123);
        rd(12'h341, d);
        checks++; if (d !== 32'h120) begin errors++; $display("FAIL mepc_align got %h exp 120", d); end
        csr_addr = 12'h344; csr_op = 2'b01; csr_wdata = 32'hFFFF_FFFF;
        #1;
        checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL mip_write_illegal got %b exp 1", csr_illegal); end
        @(negedge clk);
        csr_op = 2'b00;
        rd(12'h344, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL mip_unchanged got %h exp 0", d); end
        csr_addr = 12'h7C0; csr_op = 2'b10;
        #1;
        checks++; if (csr_illegal !== 1'b1 || csr_rdata !== 32'h0) begin errors++;
            $display("FAIL unimpl_access got ill=%b rd=%h exp ill=1 rd=0", csr_illegal, csr_rdata); end
        csr_op = 2'b00; csr_addr = 12'h305;
        #1;
        checks++; if (csr_illegal !== 1'b0 || csr_rdata !== 32'h0) begin errors++;
            $display("FAIL op_none got ill=%b rd=%h exp ill=0 rd=0", csr_illegal, csr_rdata); end
`ifndef CSR_COUNTERS_EN
        csr_addr = 12'hB00; csr_op = 2'b10;
        #1;
        checks++; if (csr_illegal !== 1'b1 || csr_rdata !== 32'h0) begin errors++;
            $display("FAIL counter_absent got ill=%b rd=%h exp ill=1 rd=0", csr_illegal, csr_rdata); end
        csr_op = 2'b00;
`endif
        wr(12'h300, 2'b01, 32'h0);
    endtask

`ifdef CSR_COUNTERS_EN
    task automatic test_counters();
        logic [31:0] lo, hi;
        wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
        wr(12'hB80, 2'b01, 32'hFFFF_FFFF);
        @(negedge clk);
        rd(12'hB00, lo);
        rd(12'hB80, hi);
        checks++; if (lo !== 32'h0 || hi !== 32'h0) begin errors++;
            $display("FAIL mcycle_wrap got %h_%h exp 0_0", hi, lo); end
    endtask
`endif

    task automatic test_trap_direct();
        logic [31:0] d;
        wr(12'h305, 2'b01, 32'h100);
        wr(12'h304, 2'b01, 32'h1_0000);
        wr(12'h300, 2'b01, 32'h8);
        pc_in = 32'h40; irq_accept = 1'b1; irq_i = 4'b0001;
        repeat (2) @(negedge clk);
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL trap_early got %b exp 0", redirect_valid); end
        @(negedge clk);
        $display("trap  v=%b pc=%h", redirect_valid, redirect_pc);
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin errors++;
            $display("FAIL trap_direct got v=%b pc=%h exp v=1 pc=100", redirect_valid, redirect_pc); end
        rd(12'h341, d);
        checks++; if (d !== 32'h40) begin errors++; $display("FAIL trap_mepc got %h exp 40", d); end
        rd(12'h342, d);
        checks++; if (d !== 32'h8000_0010) begin errors++; $display("FAIL trap_mcause got %h exp 80000010", d); end
        rd(12'h300, d);
        checks++; if (d !== 32'h80) begin errors++; $display("FAIL trap_mstatus got %h exp 80", d); end
        @(negedge clk);
        checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h100) begin errors++;
            $display("FAIL pulse_end got v=%b pc=%h exp v=0 pc=100", redirect_valid, redirect_pc); end
        rd(12'h344, d);
        checks++; if (d !== 32'h1_0000) begin errors++; $display("FAIL mip_pending got %h exp 10000", d); end
    endtask

    task automatic test_mret();
        logic [31:0] d;
        is_mret = 1'b1;
        @(negedge clk);
        is_mret = 1'b0; pc_in = 32'h44;
        $display("mret  v=%b pc=%h", redirect_valid, redirect_pc);
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h40) begin errors++;
            $display("FAIL mret_redirect got v=%b pc=%h exp v=1 pc=40", redirect_valid, redirect_pc); end
        rd(12'h300, d);
        checks++; if (d !== 32'h88) begin errors++; $display("FAIL mret_mstatus got %h exp 88", d); end
        @(negedge clk);
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin errors++;
            $display("FAIL retrap got v=%b pc=%h exp v=1 pc=100", redirect_valid, redirect_pc); end
        rd(12'h341, d);
        checks++; if (d !== 32'h44) begin errors++; $display("FAIL retrap_mepc got %h exp 44", d); end
        irq_i = '0; irq_accept = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_vectored();
        logic [31:0] d;
        wr(12'h305, 2'b01, 32'h101);
        wr(12'h304, 2'b01, 32'h4_0080);
        irq_i = 4'b0100; timer_irq = 1'b1;
        repeat (3) @(negedge clk);
        wr(12'h300, 2'b01, 32'h8);
        pc_in = 32'h80; irq_accept = 1'b1;
        @(negedge clk);
        $display("vtrap v=%b pc=%h", redirect_valid, redirect_pc);
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h148) begin errors++;
            $display("FAIL vectored_pc got v=%b pc=%h exp v=1 pc=148", redirect_valid, redirect_pc); end
        rd(12'h342, d);
        checks++; if (d !== 32'h8000_0012) begin errors++; $display("FAIL vectored_mcause got %h exp 80000012", d); end
    endtask

    task automatic test_timer_vs_csr();
        logic [31:0] d;
        irq_i = '0;
        repeat (3) @(negedge clk);
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL no_retrap_mie0 got %b exp 0", redirect_valid); end
        is_mret = 1'b1;
        @(negedge clk);
        is_mret = 1'b0;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80) begin errors++;
            $display("FAIL mret_priority got v=%b pc=%h exp v=1 pc=80", redirect_valid, redirect_pc); end
        csr_addr = 12'h304; csr_op = 2'b01; csr_wdata = 32'h0;
        #1;
        checks++; if (csr_rdata !== 32'h4_0080) begin errors++; $display("FAIL trap_cycle_rdata got %h exp 40080", csr_rdata); end
        @(negedge clk);
        csr_op = 2'b00;
        $display("ttrap v=%b pc=%h", redirect_valid, redirect_pc);
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h11C) begin errors++;
            $display("FAIL timer_pc got v=%b pc=%h exp v=1 pc=11c", redirect_valid, redirect_pc); end
        rd(12'h304, d);
        checks++; if (d !== 32'h4_0080) begin errors++; $display("FAIL write_dropped got %h exp 40080", d); end
        rd(12'h342, d);
        checks++; if (d !== 32'h8000_0007) begin errors++; $display("FAIL timer_mcause got %h exp 80000007", d); end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] d;
        timer_irq = 1'b0; irq_accept = 1'b0;
        is_mret = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80) begin errors++;
            $display("FAIL pre_reset_pulse got v=%b pc=%h exp v=1 pc=80", redirect_valid, redirect_pc); end
        rst_n = 1'b0;
        #1;
        is_mret = 1'b0;
        checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin errors++;
            $display("FAIL async_reset got v=%b pc=%h exp v=0 pc=0", redirect_valid, redirect_pc); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL post_reset_pulse got %b exp 0", redirect_valid); end
        rd(12'h305, d);
        checks++; if (d !== RST_TVEC) begin errors++; $display("FAIL midrun_mtvec got %h exp %h", d, RST_TVEC); end
        rd(12'h341, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrun_mepc got %h exp 0", d); end
        rd(12'h300, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrun_mstatus got %h exp 0", d); end
    endtask

    initial begin
        test_reset();
        test_csr_ops();
`ifdef CSR_COUNTERS_EN
        test_counters();
`endif
        test_trap_direct();
        test_mret();
        test_vectored();
        test_timer_vs_csr();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/csr_file_v2.md
CSR_FILE_V2 -- requirements
Module: csr_file_v2

Interface
REQ-001 SHALL provide parameter NUM_IRQ, default 4, number of external interrupt lines (1..16).
REQ-002 SHALL provide parameter RESET_MTVEC, default 32'h0000_0000, mtvec value after reset.
REQ-003 SHALL provide parameter SYNC_STAGES, default 2, synchroniser depth for irq inputs (>=2).
REQ-004 SHALL provide ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- csr_addr  in  12  CSR address
- csr_op  in  2  00 none, 01 write, 10 set-bits, 11 clear-bits
- csr_wdata  in  32  write/mask operand
- csr_rdata  out  32  combinational read data
- csr_illegal  out  1  addressed CSR unimplemented while csr_op!=00
- instr_retire  in  1  one instruction retired this cycle
- irq_accept  in  1  pipeline at interruptible instruction boundary
- pc_in  in  32  PC of next instruction to execute
- is_mret  in  1  MRET executing
- irq_i  in  NUM_IRQ  asynchronous external interrupts, level
- timer_irq  in  1  synchronous timer interrupt, level
- redirect_valid  out  1  one-cycle PC redirect pulse
- redirect_pc  out  32  redirect target

Function
REQ-005 SHALL implement mstatus 0x300 (MIE bit3, MPIE bit7, others read 0), mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342, mip 0x344 (read-only).
REQ-006 SHALL read csr_rdata combinationally; unimplemented address or csr_op=00 returns 0.
REQ-007 SHALL update target CSR on the clock edge: write=wdata, set=old|wdata, clear=old&~wdata; mepc bits[1:0] forced 0.
REQ-008 SHALL ignore writes to mip and to unimplemented addresses, asserting csr_illegal.
REQ-009 SHALL pass irq_i through SYNC_STAGES flops; mip bit7=timer_irq, mip bit(16+i)=synchronised irq_i[i].
REQ-010 SHALL take trap when mstatus.MIE=1, irq_accept=1, is_mret=0, and (mip & mie)!=0.
REQ-011 SHALL prioritise irq_i[0] highest, ascending index, timer lowest; cause code 16+i or 7.
REQ-012 SHALL on trap edge: mepc<=pc_in, mcause<={1'b1,cause code}, MPIE<=MIE, MIE<=0.
REQ-013 SHALL on trap edge register redirect_valid=1, redirect_pc=mtvec[31:2]<<2 if mtvec[1:0]=00, else that base + 4*code (vectored, mtvec[1:0]=01).
REQ-014 SHALL on is_mret edge: MIE<=MPIE, MPIE<=1, redirect_valid=1, redirect_pc=mepc.
REQ-015 SHALL deassert redirect_valid the cycle after any pulse absent a new event; redirect_pc holds last value.
REQ-016 SHALL give is_mret priority over a pending interrupt in the same cycle; interrupt becomes eligible next cycle once MIE restored.
REQ-017 SHALL give trap priority over a same-cycle CSR access: the write is dropped, csr_rdata still valid.
REQ-018 SHALL not re-trap while MIE=0; interrupts remain pending in mip.

Reset
REQ-019 SHALL on rst_n low asynchronously clear mstatus, mie, mepc, mcause, sync flops, counters, redirect_valid, redirect_pc; mtvec<=RESET_MTVEC.
REQ-020 SHALL abandon any in-flight redirect on reset; no pulse follows reset deassertion.

Configuration
REQ-021 SHALL compile 64-bit counters mcycle (0xB00/0xB80) and minstret (0xB02/0xB82) only when CSR_COUNTERS_EN is defined.
REQ-022 With CSR_COUNTERS_EN: mcycle increments every cycle, minstret on instr_retire, wrap 2^64-1 to 0; a CSR write to either half wins over increment that cycle.
REQ-023 Without CSR_COUNTERS_EN: counter addresses read 0, flag csr_illegal, no counter flops exist.

Verification
REQ-024 Write mtvec=0x100, mie=0x10000, mstatus=0x8; raise irq_i[0], irq_accept=1, pc_in=0x40 -> after SYNC_STAGES+1 edges redirect_pc=0x100, mepc=0x40, mcause=0x8000_0010, MIE=0.
REQ-025 mtvec=0x101, irq_i[2] and timer both pending/enabled -> redirect_pc=0x100+4*18=0x148, mcause=0x8000_0012.
REQ-026 After REQ-024 trap, pulse is_mret with irq_i[0] still high -> redirect_pc=0x40, MIE=1; next cycle re-trap.
REQ-027 Set-bits op 0x80 then clear-bits op 0x8 on mstatus from 0x8 -> reads 0x88 then 0x80; write to 0x344 -> mip unchanged, csr_illegal=1.
REQ-028 CSR_COUNTERS_EN: write mcycle=0xFFFF_FFFF, mcycleh=0xFFFF_FFFF -> next cycle reads 0/0; assert rst_n mid-run -> all outputs 0, mtvec=RESET_MTVEC.
